// File: rtl/regwin_pkg.sv
// Shared constants, window-op encoding and the architectural-to-physical register map
// for the windowed SPARC register file. Independent of the number of windows.
package regwin_pkg;

    localparam int WIN_REGS = 16;

    localparam logic [4:0] REG_G0 = 5'd0;
    localparam logic [4:0] REG_O0 = 5'd8;
    localparam logic [4:0] REG_SP = 5'd14;
    localparam logic [4:0] REG_O7 = 5'd15;
    localparam logic [4:0] REG_L0 = 5'd16;
    localparam logic [4:0] REG_I0 = 5'd24;
    localparam logic [4:0] REG_FP = 5'd30;
    localparam logic [4:0] REG_I7 = 5'd31;

    typedef enum logic {
        WIN_SAVE    = 1'b0,
        WIN_RESTORE = 1'b1
    } win_op_e;

    // Globals map straight through; outs/locals/ins rotate with cwp so that the ins of
    // window w land on the outs of window w+1, wrapping at the top window.
    function automatic logic [9:0] phys_idx(input logic [4:0] idx, input logic [4:0] cwp,
                                            input int unsigned nwin);
        int unsigned off;
        if (idx < REG_O0)
            return {5'd0, idx};
        off = (32'(cwp) * WIN_REGS + 32'(idx) - 32'(REG_O0)) % (WIN_REGS * nwin);
        return 10'(off + 32'(REG_O0));
    endfunction

endpackage

// File: rtl/sparc_window_regfile_if.sv
// Operand-read, claim, writeback, window-op and WIM signals of the windowed register file.
// The core drives through master; the register file sits on slave.
interface sparc_window_regfile_if #(
    parameter int NWINDOWS = 8,
    parameter int NREAD    = 3,
    parameter int NWRITE   = 2
);
    localparam int PW = $clog2(8 + 16 * NWINDOWS);

    logic [NREAD*5-1:0]   rd_addr;
    logic [NREAD*32-1:0]  rd_data;
    logic [NREAD-1:0]     rd_busy;
    logic                 claim_valid;
    logic [4:0]           claim_addr;
    logic [PW-1:0]        claim_phys;
    logic [NWRITE-1:0]    wr_valid;
    logic [NWRITE*PW-1:0] wr_phys;
    logic [NWRITE*32-1:0] wr_data;
    logic                 win_valid;
    logic                 win_restore;
    logic                 win_ready;
    logic                 win_done;
    logic                 win_trap;
    logic [4:0]           cwp;
    logic                 wim_we;
    logic [NWINDOWS-1:0]  wim_wdata;
    logic [NWINDOWS-1:0]  wim;

    modport master (
        output rd_addr, claim_valid, claim_addr, wr_valid, wr_phys, wr_data,
               win_valid, win_restore, wim_we, wim_wdata,
        input  rd_data, rd_busy, claim_phys, win_ready, win_done, win_trap, cwp, wim
    );

    modport slave (
        input  rd_addr, claim_valid, claim_addr, wr_valid, wr_phys, wr_data,
               win_valid, win_restore, wim_we, wim_wdata,
        output rd_data, rd_busy, claim_phys, win_ready, win_done, win_trap, cwp, wim
    );

endinterface

// File: rtl/regwin_scoreboard.sv
// Per-physical-register busy bits: set by issue claims, cleared by writeback, claim wins a tie.
// win_ready is low while any windowed register (r8..r31 of any window) is still outstanding.
module regwin_scoreboard
    import regwin_pkg::*;
#(
    parameter int NREGS = 136
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREGS-1:0] set_vec,
    input  logic [NREGS-1:0] clr_vec,
    output logic [NREGS-1:0] busy,
    output logic             win_ready
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            busy <= '0;
        else
            busy <= (busy & ~clr_vec) | set_vec;
    end

    assign win_ready = ~|busy[NREGS-1:int'(REG_O0)];

endmodule

// File: rtl/sparc_window_regfile.sv
// Windowed integer register file: bypassed operand reads, writeback, scoreboard, SAVE/RESTORE.
// Reads are combinational; window ops commit one cycle after acceptance, stalled by win_ready.
module sparc_window_regfile
    import regwin_pkg::*;
#(
    parameter int NWINDOWS  = 8,
    parameter int NREAD     = 3,
    parameter int NWRITE    = 2,
    parameter int CWP_RESET = 7
) (
    input  logic                   clk,
    input  logic                   reset,
    sparc_window_regfile_if.slave  bus
);

    localparam int NREGS = 8 + 16 * NWINDOWS;
    localparam int PW    = $clog2(NREGS);
    localparam int CW    = $clog2(NWINDOWS);

    logic [31:0]         regs [NREGS];
    logic [PW-1:0]       wp   [NWRITE];
    logic [31:0]         wd   [NWRITE];
    logic [PW-1:0]       rp   [NREAD];
    logic [NREGS-1:0]    set_vec;
    logic [NREGS-1:0]    clr_vec;
    logic [NREGS-1:0]    busy;
    logic                win_ready;
    logic [CW-1:0]       cwp_q;
    logic [CW-1:0]       win_tgt;
    logic [NWINDOWS-1:0] wim_q;
    logic                done_q;
    logic                trap_q;
    logic                win_acc;
    win_op_e             win_op;

    function automatic logic [PW-1:0] map_reg(input logic [4:0] idx, input logic [CW-1:0] cw);
        return PW'(phys_idx(idx, 5'(cw), NWINDOWS));
    endfunction

    // Physical 0 is %g0: never stored, never bypassed, never marked busy.
    always_comb begin
        clr_vec = '0;
        for (int w = 0; w < NWRITE; w++) begin
            wp[w] = bus.wr_phys[w*PW +: PW];
            wd[w] = bus.wr_data[w*32 +: 32];
            if (bus.wr_valid[w] && wp[w] != '0)
                clr_vec[wp[w]] = 1'b1;
        end
    end

    assign bus.claim_phys = map_reg(bus.claim_addr, cwp_q);

    always_comb begin
        set_vec = '0;
        if (bus.claim_valid && bus.claim_phys != '0)
            set_vec[bus.claim_phys] = 1'b1;
    end

    regwin_scoreboard #(.NREGS(NREGS)) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .set_vec   (set_vec),
        .clr_vec   (clr_vec),
        .busy      (busy),
        .win_ready (win_ready)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else begin
            for (int w = 0; w < NWRITE; w++)
                if (bus.wr_valid[w] && wp[w] != '0)
                    regs[wp[w]] <= wd[w];
        end
    end

    // Later write ports override earlier ones, matching the storage priority above.
    always_comb begin
        bus.rd_data = '0;
        bus.rd_busy = '0;
        for (int r = 0; r < NREAD; r++) begin
            rp[r] = map_reg(bus.rd_addr[r*5 +: 5], cwp_q);
            bus.rd_data[r*32 +: 32] = regs[rp[r]];
            for (int w = 0; w < NWRITE; w++)
                if (bus.wr_valid[w] && wp[w] != '0 && wp[w] == rp[r])
                    bus.rd_data[r*32 +: 32] = wd[w];
            bus.rd_busy[r] = busy[rp[r]] & ~clr_vec[rp[r]];
        end
    end

    assign win_op  = win_op_e'(bus.win_restore);
    assign win_tgt = (win_op == WIN_SAVE) ? cwp_q - 1'b1 : cwp_q + 1'b1;
    assign win_acc = bus.win_valid && win_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cwp_q  <= CW'(CWP_RESET);
            wim_q  <= '0;
            done_q <= 1'b0;
            trap_q <= 1'b0;
        end else begin
            done_q <= win_acc && !wim_q[win_tgt];
            trap_q <= win_acc && wim_q[win_tgt];
            if (win_acc && !wim_q[win_tgt])
                cwp_q <= win_tgt;
            if (bus.wim_we)
                wim_q <= bus.wim_wdata;
        end
    end

    assign bus.win_ready = win_ready;
    assign bus.win_done  = done_q;
    assign bus.win_trap  = trap_q;
    assign bus.cwp       = 5'(cwp_q);
    assign bus.wim       = wim_q;

endmodule

// File: tb/tb_sparc_window_regfile.sv
// Bench for sparc_window_regfile: directed vector table, hand-written window/reset sequences,
// then randomized traffic against a behavioural register-window model.
module tb_sparc_window_regfile;
    import regwin_pkg::*;

    localparam int NW    = 8;
    localparam int NR    = 3;
    localparam int NWR   = 2;
    localparam int NREGS = 8 + 16 * NW;
    localparam int PW    = $clog2(NREGS);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sparc_window_regfile_if #(.NWINDOWS(NW), .NREAD(NR), .NWRITE(NWR)) bus ();

    sparc_window_regfile #(.NWINDOWS(NW), .NREAD(NR), .NWRITE(NWR), .CWP_RESET(7)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0]   m_regs [NREGS];
    bit            m_busy [NREGS];
    int            m_cwp;
    logic [NW-1:0] m_wim;
    bit            m_done, m_trap;

    function automatic int tphys(input int idx, input int cw);
        if (idx < 8) return idx;
        return 8 + (cw * 16 + idx - 8) % (16 * NW);
    endfunction

    function automatic bit m_ready();
        for (int i = 8; i < NREGS; i++)
            if (m_busy[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_cwp = 7; m_wim = '0; m_done = 1'b0; m_trap = 1'b0;
    endtask

    task automatic m_step();
        bit acc;
        int tgt, cp, p;
        acc = bus.win_valid && m_ready();
        tgt = bus.win_restore ? (m_cwp + 1) % NW : (m_cwp + NW - 1) % NW;
        cp  = tphys(int'(bus.claim_addr), m_cwp);
        for (int w = 0; w < NWR; w++) begin
            p = int'(bus.wr_phys[w*PW +: PW]);
            if (bus.wr_valid[w] && p != 0) begin
                m_regs[p] = bus.wr_data[w*32 +: 32];
                m_busy[p] = 1'b0;
            end
        end
        if (bus.claim_valid && cp != 0) m_busy[cp] = 1'b1;
        m_done = 1'b0; m_trap = 1'b0;
        if (acc) begin
            if (m_wim[tgt]) m_trap = 1'b1;
            else begin m_cwp = tgt; m_done = 1'b1; end
        end
        if (bus.wim_we) m_wim = bus.wim_wdata;
    endtask

    task automatic m_check(input string tag);
        int p;
        logic [31:0] v;
        bit b;
        for (int r = 0; r < NR; r++) begin
            p = tphys(int'(bus.rd_addr[r*5 +: 5]), m_cwp);
            v = (p == 0) ? 32'd0 : m_regs[p];
            b = m_busy[p];
            for (int w = 0; w < NWR; w++)
                if (bus.wr_valid[w] && p != 0 && int'(bus.wr_phys[w*PW +: PW]) == p) begin
                    v = bus.wr_data[w*32 +: 32];
                    b = 1'b0;
                end
            chk($sformatf("%s_rd%0d", tag, r), bus.rd_data[r*32 +: 32], v);
            chk($sformatf("%s_busy%0d", tag, r), bus.rd_busy[r], b);
        end
        chk({tag, "_claim_phys"}, bus.claim_phys, tphys(int'(bus.claim_addr), m_cwp));
        chk({tag, "_win_ready"}, bus.win_ready, m_ready());
        chk({tag, "_cwp"}, bus.cwp, m_cwp);
        chk({tag, "_wim"}, bus.wim, m_wim);
        chk({tag, "_done"}, bus.win_done, m_done);
        chk({tag, "_trap"}, bus.win_trap, m_trap);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        bus.claim_valid = 1'b0; bus.claim_addr = '0;
        bus.wr_valid = '0; bus.wr_phys = '0; bus.wr_data = '0;
        bus.win_valid = 1'b0; bus.win_restore = 1'b0;
        bus.wim_we = 1'b0; bus.wim_wdata = '0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        idle();
        m_reset();
        #4 reset = 1'b0;
    endtask

    typedef struct packed {
        logic        cv;
        logic [4:0]  ca;
        logic [1:0]  wv;
        logic [7:0]  wp0;
        logic [31:0] wd0;
        logic [7:0]  wp1;
        logic [31:0] wd1;
        logic        winv;
        logic        winr;
        logic        wimwe;
        logic [7:0]  wimd;
        logic [4:0]  ra;
        logic [4:0]  e_cwp;
        logic        e_done;
        logic        e_trap;
        logic [31:0] e_rd;
        logic        e_busy;
    } vec_t;

    function automatic vec_t mk(input logic cv, input logic [4:0] ca, input logic [1:0] wv,
        input logic [7:0] wp0, input logic [31:0] wd0, input logic [7:0] wp1, input logic [31:0] wd1,
        input logic winv, input logic winr, input logic wimwe, input logic [7:0] wimd,
        input logic [4:0] ra, input logic [4:0] e_cwp, input logic e_done, input logic e_trap,
        input logic [31:0] e_rd, input logic e_busy);
        vec_t v;
        v.cv = cv; v.ca = ca; v.wv = wv; v.wp0 = wp0; v.wd0 = wd0; v.wp1 = wp1; v.wd1 = wd1;
        v.winv = winv; v.winr = winr; v.wimwe = wimwe; v.wimd = wimd; v.ra = ra;
        v.e_cwp = e_cwp; v.e_done = e_done; v.e_trap = e_trap; v.e_rd = e_rd; v.e_busy = e_busy;
        return v;
    endfunction

    vec_t tv [13];

    initial begin
        int q[$];
        int p;

        reset = 1'b0;
        idle();
        bus.rd_addr = '0;
        m_reset();
        #2 reset = 1'b1;
        #10 reset = 1'b0;

        // Reset state
        bus.rd_addr = {5'd31, 5'd9, 5'd8};
        #1;
        for (int r = 0; r < NR; r++) begin
            chk($sformatf("reset_rd%0d", r), bus.rd_data[r*32 +: 32], 32'd0);
            chk($sformatf("reset_busy%0d", r), bus.rd_busy[r], 1'b0);
        end
        chk("reset_cwp", bus.cwp, 5'd7);
        chk("reset_wim", bus.wim, 8'h00);
        chk("reset_win_ready", bus.win_ready, 1'b1);
        chk("reset_done", bus.win_done, 1'b0);
        chk("reset_trap", bus.win_trap, 1'b0);

        //          cv ca    wv     wp0   wd0            wp1   wd1            wv wr we wimd   ra     cwp  d  t  rd             busy
        tv[0]  = mk(1, 5'd9, 2'b01, 8'd121, 32'hDEADBEEF, 8'd0, 32'd0,       0, 0, 0, 8'h00, 5'd9,  5'd7, 0, 0, 32'hDEADBEEF, 1);
        tv[1]  = mk(0, 5'd0, 2'b01, 8'd121, 32'hDEADBEEF, 8'd0, 32'd0,       0, 0, 0, 8'h00, 5'd9,  5'd7, 0, 0, 32'hDEADBEEF, 0);
        tv[2]  = mk(0, 5'd0, 2'b01, 8'd120, 32'h00001234, 8'd0, 32'd0,       0, 0, 0, 8'h00, 5'd8,  5'd7, 0, 0, 32'h00001234, 0);
        tv[3]  = mk(0, 5'd0, 2'b00, 8'd0,   32'd0,        8'd0, 32'd0,       1, 0, 0, 8'h00, 5'd24, 5'd6, 1, 0, 32'h00001234, 0);
        tv[4]  = mk(0, 5'd0, 2'b00, 8'd0,   32'd0,        8'd0, 32'd0,       1, 1, 0, 8'h00, 5'd8,  5'd7, 1, 0, 32'h00001234, 0);
        tv[5]  = mk(0, 5'd0, 2'b00, 8'd0,   32'd0,        8'd0, 32'd0,       0, 0, 1, 8'h40, 5'd8,  5'd7, 0, 0, 32'h00001234, 0);
        tv[6]  = mk(0, 5'd0, 2'b00, 8'd0,   32'd0,        8'd0, 32'd0,       1, 0, 0, 8'h00, 5'd8,  5'd7, 0, 1, 32'h00001234, 0);
        tv[7]  = mk(0, 5'd0, 2'b00, 8'd0,   32'd0,        8'd0, 32'd0,       0, 0, 1, 8'h01, 5'd8,  5'd7, 0, 0, 32'h00001234, 0);
        tv[8]  = mk(0, 5'd0, 2'b00, 8'd0,   32'd0,        8'd0, 32'd0,       1, 1, 0, 8'h00, 5'd8,  5'd7, 0, 1, 32'h00001234, 0);
        tv[9]  = mk(1, 5'd0, 2'b11, 8'd0,   32'hFFFFFFFF, 8'd0, 32'hFFFFFFFF, 0, 0, 0, 8'h00, 5'd0,  5'd7, 0, 0, 32'd0,        0);
        tv[10] = mk(0, 5'd0, 2'b00, 8'd0,   32'd0,        8'd0, 32'd0,       0, 0, 1, 8'h00, 5'd8,  5'd7, 0, 0, 32'h00001234, 0);
        tv[11] = mk(0, 5'd0, 2'b00, 8'd0,   32'd0,        8'd0, 32'd0,       1, 1, 0, 8'h00, 5'd8,  5'd0, 1, 0, 32'd0,        0);
        tv[12] = mk(0, 5'd0, 2'b11, 8'd20,  32'hAAAA0000, 8'd20, 32'h55551111, 0, 0, 0, 8'h00, 5'd20, 5'd0, 0, 0, 32'h55551111, 0);

        for (int i = 0; i < 13; i++) begin
            bus.claim_valid = tv[i].cv;   bus.claim_addr  = tv[i].ca;
            bus.wr_valid    = tv[i].wv;
            bus.wr_phys     = {tv[i].wp1, tv[i].wp0};
            bus.wr_data     = {tv[i].wd1, tv[i].wd0};
            bus.win_valid   = tv[i].winv; bus.win_restore = tv[i].winr;
            bus.wim_we      = tv[i].wimwe; bus.wim_wdata  = tv[i].wimd;
            bus.rd_addr     = {5'd0, 5'd0, tv[i].ra};
            @(posedge clk);
            #1 idle();
            #1;
            chk($sformatf("vec%0d_cwp", i), bus.cwp, tv[i].e_cwp);
            chk($sformatf("vec%0d_done", i), bus.win_done, tv[i].e_done);
            chk($sformatf("vec%0d_trap", i), bus.win_trap, tv[i].e_trap);
            chk($sformatf("vec%0d_rd", i), bus.rd_data[31:0], tv[i].e_rd);
            chk($sformatf("vec%0d_busy", i), bus.rd_busy[0], tv[i].e_busy);
        end

        // Claim r10 at cwp 0, write it back the following cycle: busy for one cycle, then bypass.
        bus.rd_addr = {5'd0, 5'd0, 5'd10};
        bus.claim_valid = 1'b1; bus.claim_addr = 5'd10;
        #1 chk("seqA_claim_phys", bus.claim_phys, 8'd10);
        @(posedge clk);
        #1 idle();
        #1;
        chk("seqA_busy_set", bus.rd_busy[0], 1'b1);
        chk("seqA_ready_low", bus.win_ready, 1'b0);
        bus.wr_valid = 2'b01; bus.wr_phys = {8'd0, 8'd10}; bus.wr_data = {32'd0, 32'hDEADBEEF};
        #1;
        chk("seqA_bypass_rd", bus.rd_data[31:0], 32'hDEADBEEF);
        chk("seqA_bypass_busy", bus.rd_busy[0], 1'b0);
        @(posedge clk);
        #1 idle();
        #1;
        chk("seqA_stored_rd", bus.rd_data[31:0], 32'hDEADBEEF);
        chk("seqA_busy_clear", bus.rd_busy[0], 1'b0);
        chk("seqA_ready_high", bus.win_ready, 1'b1);

        // SAVE held against an outstanding windowed claim commits only after writeback.
        do_reset();
        bus.claim_valid = 1'b1; bus.claim_addr = 5'd16;
        @(posedge clk);
        #1 idle();
        bus.win_valid = 1'b1; bus.win_restore = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("seqB_wait%0d_done", i), bus.win_done, 1'b0);
            chk($sformatf("seqB_wait%0d_ready", i), bus.win_ready, 1'b0);
            chk($sformatf("seqB_wait%0d_cwp", i), bus.cwp, 5'd7);
            @(posedge clk);
            #1;
        end
        bus.wr_valid = 2'b01; bus.wr_phys = {8'd0, 8'd128}; bus.wr_data = {32'd0, 32'h0BADF00D};
        @(posedge clk);
        #1 bus.wr_valid = 2'b00;
        #1;
        chk("seqB_ready_after_wb", bus.win_ready, 1'b1);
        chk("seqB_no_done_yet", bus.win_done, 1'b0);
        @(posedge clk);
        #1;
        chk("seqB_done", bus.win_done, 1'b1);
        chk("seqB_cwp6", bus.cwp, 5'd6);
        bus.win_valid = 1'b0;
        @(posedge clk);
        #1 chk("seqB_done_pulse", bus.win_done, 1'b0);

        // Reset while a SAVE waits on a claim.
        bus.claim_valid = 1'b1; bus.claim_addr = 5'd16;
        #1 chk("seqC_claim_phys", bus.claim_phys, 8'd112);
        @(posedge clk);
        #1 idle();
        bus.win_valid = 1'b1;
        @(posedge clk);
        #1 chk("seqC_ready_low", bus.win_ready, 1'b0);
        reset = 1'b1;
        bus.win_valid = 1'b0;
        #1;
        chk("seqC_reset_cwp", bus.cwp, 5'd7);
        chk("seqC_reset_ready", bus.win_ready, 1'b1);
        #2 reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("seqC_post%0d_done", i), bus.win_done, 1'b0);
            chk($sformatf("seqC_post%0d_trap", i), bus.win_trap, 1'b0);
            chk($sformatf("seqC_post%0d_cwp", i), bus.cwp, 5'd7);
        end

        // Reset landing on the edge that would have accepted a SAVE.
        bus.win_valid = 1'b1;
        #1 reset = 1'b1;
        bus.win_valid = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("seqD_cwp", bus.cwp, 5'd7);
        chk("seqD_done", bus.win_done, 1'b0);

        // Randomized traffic against the model.
        do_reset();
        m_reset();
        for (int c = 0; c < 600; c++) begin
            q.delete();
            for (int i = 1; i < NREGS; i++)
                if (m_busy[i]) q.push_back(i);
            bus.claim_valid = ($urandom_range(9) < 3);
            bus.claim_addr  = 5'($urandom_range(31));
            for (int w = 0; w < NWR; w++) begin
                bus.wr_valid[w] = $urandom_range(1);
                if (q.size() > 0 && $urandom_range(9) < 7)
                    p = q[$urandom_range(q.size() - 1)];
                else
                    p = $urandom_range(NREGS - 1);
                bus.wr_phys[w*PW +: PW] = PW'(p);
                bus.wr_data[w*32 +: 32] = $urandom;
            end
            bus.win_valid   = ($urandom_range(4) == 0);
            bus.win_restore = $urandom_range(1);
            bus.wim_we      = ($urandom_range(19) == 0);
            bus.wim_wdata   = NW'($urandom) & NW'($urandom);
            for (int r = 0; r < NR; r++)
                bus.rd_addr[r*5 +: 5] = 5'($urandom_range(31));
            #1 m_check($sformatf("rnd%0d", c));
            @(posedge clk);
            m_step();
            #1;
        end
        idle();
        #1 m_check("rnd_final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
